// File: rtl/r2div_srt.sv
// r2div_srt: sequential radix-2 SRT divider for W-bit normalized unsigned fractions.
// Computes Q, R with {X, W'b0} = Q*D + R, 0 <= R < D, in W iterations plus one fix-up cycle.
// Carry-save residual, digit set {-1,0,+1}, on-the-fly quotient conversion.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_start  start request, sampled only when idle
//   i_x      dividend X (fraction, X < D required)
//   i_d      divisor D (fraction, bit W-1 must be set)
//   o_busy   high while iterating and during the fix-up cycle
//   o_valid  one-cycle pulse when o_q/o_rem/o_err are updated
//   o_q      quotient
//   o_rem    remainder
//   o_err    last accepted request had invalid operands
module r2div_srt #(
    parameter int unsigned W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_d,
    output logic         o_busy,
    output logic         o_valid,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_rem,
    output logic         o_err
);

    // Residual: 3 integer bits (two's complement) + W fraction bits.
    localparam int unsigned RW = W + 3;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_e;

    state_e        state_q;
    logic [RW-1:0] ws_q;
    logic [RW-1:0] wc_q;
    logic [W-1:0]  d_q;
    logic [W-1:0]  q_q;
    logic [W-1:0]  qm_q;
    logic [CW-1:0] cnt_q;

    logic [RW-1:0] dext_c;
    logic [RW-1:0] ws2_c;
    logic [RW-1:0] wc2_c;
    logic [3:0]    est_c;
    logic          dig_pos_c;
    logic          dig_zero_c;
    logic          dig_neg_c;
    logic [RW-1:0] addend_c;
    logic [RW-2:0] carry_c;
    logic [RW-1:0] ws_d;
    logic [RW-1:0] wc_d;
    logic [W-1:0]  q_d;
    logic [W-1:0]  qm_d;
    logic [RW-1:0] wf_c;
    logic          wf_neg_c;
    logic [RW-1:0] rfix_c;
    logic [RW-1:0] wmag_c;
    logic          res_ok_c;
    logic          op_err_c;

    // Invalid operands: unnormalized divisor or quotient would not fit in W bits.
    assign op_err_c = ~i_d[W-1] | (i_x >= i_d);

    // Iteration datapath: estimate, digit select, 3:2 residual update, on-the-fly conversion.
    always_comb begin
        dext_c     = {3'b000, d_q};
        ws2_c      = {ws_q[RW-2:0], 1'b0};
        wc2_c      = {wc_q[RW-2:0], 1'b0};
        // Top 4 bits of 2WS and 2WC (3 integer + 1 fraction), in units of 1/2.
        est_c      = ws_q[W+1:W-2] + wc_q[W+1:W-2];
        dig_zero_c = (est_c == 4'b1111);
        dig_pos_c  = ~est_c[3];
        dig_neg_c  = est_c[3] & ~dig_zero_c;

        addend_c = '0;
        if (dig_pos_c) begin
            addend_c = ~dext_c;
        end else if (dig_neg_c) begin
            addend_c = dext_c;
        end

        ws_d    = ws2_c ^ wc2_c ^ addend_c;
        carry_c = (ws2_c[RW-2:0] & wc2_c[RW-2:0])
                | (ws2_c[RW-2:0] & addend_c[RW-2:0])
                | (wc2_c[RW-2:0] & addend_c[RW-2:0]);
        // The +1 completing -D rides in the free LSB of the shifted carry vector.
        wc_d    = {carry_c, dig_pos_c};

        q_d  = {q_q[W-2:0], 1'b0};
        qm_d = {qm_q[W-2:0], 1'b1};
        if (dig_pos_c) begin
            q_d  = {q_q[W-2:0], 1'b1};
            qm_d = {q_q[W-2:0], 1'b0};
        end else if (dig_neg_c) begin
            q_d  = {qm_q[W-2:0], 1'b1};
            qm_d = {qm_q[W-2:0], 1'b0};
        end
    end

    // Final carry-propagate and sign correction; also feeds the residual bound check.
    always_comb begin
        wf_c     = ws_q + wc_q;
        wf_neg_c = wf_c[RW-1];
        rfix_c   = wf_neg_c ? (wf_c + dext_c) : wf_c;
        wmag_c   = wf_neg_c ? (~wf_c + RW'(1)) : wf_c;
        res_ok_c = (wmag_c <= dext_c);
    end

    // Control and state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ws_q    <= '0;
            wc_q    <= '0;
            d_q     <= '0;
            q_q     <= '0;
            qm_q    <= '0;
            cnt_q   <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_q     <= '0;
            o_rem   <= '0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        d_q <= i_d;
                        if (op_err_c) begin
                            o_q     <= '1;
                            o_rem   <= '0;
                            o_err   <= 1'b1;
                            o_valid <= 1'b1;
                        end else begin
                            ws_q    <= {3'b000, i_x};
                            wc_q    <= '0;
                            q_q     <= '0;
                            qm_q    <= '0;
                            cnt_q   <= '0;
                            o_err   <= 1'b0;
                            o_busy  <= 1'b1;
                            state_q <= ITER;
                        end
                    end
                end
                ITER: begin
                    ws_q  <= ws_d;
                    wc_q  <= wc_d;
                    q_q   <= q_d;
                    qm_q  <= qm_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    o_q     <= wf_neg_c ? qm_q : q_q;
                    o_rem   <= rfix_c[W-1:0];
                    o_valid <= 1'b1;
                    o_busy  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Residual stays within [-D, D]; corrected residual has no integer bits.
    always_ff @(posedge i_clk) begin
        if (!i_rst && state_q == ITER) begin
            assert (res_ok_c);
        end
        if (!i_rst && state_q == FIX) begin
            assert (rfix_c[RW-1:W] == '0);
        end
    end

endmodule

// File: tb/tb_r2div_srt.sv
// tb_r2div_srt: self-checking bench for r2div_srt; reference model is plain integer division.
module tb_r2div_srt;

    localparam int unsigned W = 24;
    localparam int LAT = 25;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] d;
    logic         busy;
    logic         valid;
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         err;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    r2div_srt #(.W(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_x     (x),
        .i_d     (d),
        .o_busy  (busy),
        .o_valid (valid),
        .o_q     (q),
        .o_rem   (rem),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: floor({X,0}/D) and remainder, or the error response.
    task automatic model(input logic [W-1:0] mx, input logic [W-1:0] md,
                         output logic [W-1:0] mq, output logic [W-1:0] mr, output logic me);
        logic [2*W-1:0] num;
        logic [2*W-1:0] den;
        if (!md[W-1] || mx >= md) begin
            mq = '1;
            mr = '0;
            me = 1'b1;
        end else begin
            num = {mx, {W{1'b0}}};
            den = (2*W)'(md);
            mq  = W'(num / den);
            mr  = W'(num % den);
            me  = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one division from IDLE and check result, latency and busy length.
    task automatic run(input logic [W-1:0] ax, input logic [W-1:0] ad, input string tag,
                       input bit timing);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ee;
        int           j;
        int           busy_n;
        logic [2*W-1:0] lhs;
        model(ax, ad, eq, er, ee);
        x = ax;
        d = ad;
        start = 1'b1;
        tick();
        start = 1'b0;
        x = $urandom;
        d = $urandom;
        j = 0;
        busy_n = 0;
        while (!valid && j < 40) begin
            busy_n += int'(busy);
            tick();
            j++;
        end
        chk($sformatf("%s valid", tag), 64'(valid), 64'(1));
        chk($sformatf("%s q", tag), 64'(q), 64'(eq));
        chk($sformatf("%s rem", tag), 64'(rem), 64'(er));
        chk($sformatf("%s err", tag), 64'(err), 64'(ee));
        if (!ee) begin
            lhs = (2*W)'(q) * (2*W)'(ad) + (2*W)'(rem);
            chk($sformatf("%s ident", tag), 64'(lhs), 64'({ax, {W{1'b0}}}));
            chk($sformatf("%s rem<d", tag), 64'(rem < ad), 64'(1));
        end
        if (timing) begin
            chk($sformatf("%s latency", tag), 64'(j), ee ? 64'(0) : 64'(LAT));
            chk($sformatf("%s busy_cycles", tag), 64'(busy_n), ee ? 64'(0) : 64'(LAT));
            chk($sformatf("%s busy_at_valid", tag), 64'(busy), 64'(0));
            tick();
            chk($sformatf("%s valid_pulse", tag), 64'(valid), 64'(0));
        end
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ee;
        logic [W-1:0] rx;
        logic [W-1:0] rd;
        int           vt[$];
        int           seen;

        rst = 1'b1;
        start = 1'b0;
        x = '0;
        d = '0;
        repeat (3) tick();
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst valid", 64'(valid), 64'(0));
        chk("rst q", 64'(q), 64'(0));
        chk("rst rem", 64'(rem), 64'(0));
        chk("rst err", 64'(err), 64'(0));
        rst = 1'b0;
        tick();

        // Directed values from the feature list, including both error cases.
        run(24'h400000, 24'h800000, "half", 1'b1);
        chk("half q const", 64'(q), 64'h800000);
        run(24'h000001, 24'hFFFFFF, "tiny", 1'b1);
        run(24'h7FFFFF, 24'h800000, "near1", 1'b1);
        chk("near1 q const", 64'(q), 64'hFFFFFE);
        run(24'h000000, 24'h800000, "zero", 1'b1);
        run(24'h123456, 24'h400000, "unnorm", 1'b1);
        run(24'h800000, 24'h800000, "x_eq_d", 1'b1);
        run(24'hABCDEF, 24'hABCDEE, "x_gt_d", 1'b1);
        run(24'hFFFFFE, 24'hFFFFFF, "max", 1'b1);

        // Start held high: one result every LAT+1 cycles.
        model(24'h55AA55, 24'hC0FFEE, eq, er, ee);
        x = 24'h55AA55;
        d = 24'hC0FFEE;
        start = 1'b1;
        for (int c = 1; c <= 120 && vt.size() < 3; c++) begin
            tick();
            if (valid) begin
                vt.push_back(c);
                chk("b2b q", 64'(q), 64'(eq));
                chk("b2b rem", 64'(rem), 64'(er));
                if (vt.size() == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b count", 64'(vt.size()), 64'(3));
        if (vt.size() == 3) begin
            chk("b2b first", 64'(vt[0]), 64'(LAT + 1));
            chk("b2b gap1", 64'(vt[1] - vt[0]), 64'(LAT + 1));
            chk("b2b gap2", 64'(vt[2] - vt[1]), 64'(LAT + 1));
        end
        tick();
        chk("b2b idle", 64'(busy), 64'(0));

        // Start pulse mid-iteration with other operands is ignored.
        model(24'h3C3C3C, 24'hE1E1E1, eq, er, ee);
        x = 24'h3C3C3C;
        d = 24'hE1E1E1;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && !valid; c++) begin
            if (c == 8) begin
                x = 24'h000001;
                d = 24'h800001;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            seen++;
        end
        start = 1'b0;
        chk("midstart latency", 64'(seen), 64'(LAT));
        chk("midstart q", 64'(q), 64'(eq));
        chk("midstart rem", 64'(rem), 64'(er));
        tick();

        // Reset during iteration aborts without a result.
        x = 24'h654321;
        d = 24'h987654;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort valid", 64'(valid), 64'(0));
        chk("abort q", 64'(q), 64'(0));
        chk("abort rem", 64'(rem), 64'(0));
        chk("abort err", 64'(err), 64'(0));
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            seen += int'(valid) + int'(busy);
        end
        chk("abort quiet", 64'(seen), 64'(0));
        run(24'h654321, 24'h987654, "after_abort", 1'b1);

        // Random operands, mostly valid normalized pairs with occasional errors.
        for (int i = 0; i < 2000; i++) begin
            rd = W'($urandom);
            if ($urandom_range(9, 0) != 0) rd[W-1] = 1'b1;
            case ($urandom_range(3, 0))
                0:       rx = rd - W'($urandom_range(3, 0));
                1:       rx = W'($urandom_range(255, 0));
                default: rx = W'($urandom) % rd;
            endcase
            run(rx, rd, $sformatf("rnd%0d", i), (i % 64) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
